// File: rtl/riscv_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_dmem_ctrl
//
// Data-memory access controller between a RISC-V core's load/store unit and a
// simple request/acknowledge bus. Each core request becomes at most one bus
// transaction. Misaligned and reserved-size accesses are rejected without
// touching the bus. Stuck transactions are abandoned after TIMEOUT BUSY cycles.
//
// Parameters
//   XLEN     data/address width (only 32 is supported)
//   TIMEOUT  maximum BUSY cycles before the bus is abandoned (1..255)
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   dmem_req_i            core request, held high until the response cycle
//   dmem_adr_i            byte address
//   dmem_size_i           0=byte, 1=half, 2=word, 3=reserved
//   dmem_we_i             1=store, 0=load
//   dmem_d_i              store data, right-aligned
//   dmem_ack_o            one-cycle pulse: access completed
//   dmem_err_o            one-cycle pulse: bus error, timeout or reserved size
//   dmem_misaligned_o     one-cycle pulse: misaligned access, rejected
//   dmem_page_fault_o     always 0 (no MMU)
//   dmem_q_o              raw bus word of the last successful load
//   bus_req_o             bus request, high exactly while BUSY
//   bus_adr_o             word-aligned bus address
//   bus_we_o, bus_be_o    bus write strobe and byte enables
//   bus_d_o               lane-replicated write data
//   bus_ack_i, bus_err_i  bus completion / error
//   bus_q_i               bus read data
// -----------------------------------------------------------------------------
module riscv_dmem_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dmem_req_i,
  input  logic [XLEN-1:0]   dmem_adr_i,
  input  logic [1:0]        dmem_size_i,
  input  logic              dmem_we_i,
  input  logic [XLEN-1:0]   dmem_d_i,
  output logic              dmem_ack_o,
  output logic              dmem_err_o,
  output logic              dmem_misaligned_o,
  output logic              dmem_page_fault_o,
  output logic [XLEN-1:0]   dmem_q_o,
  output logic              bus_req_o,
  output logic [XLEN-1:0]   bus_adr_o,
  output logic              bus_we_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_d_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [XLEN-1:0]   bus_q_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Counter value of the last BUSY cycle the bus is allowed to take.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e            state;
  logic [7:0]        cnt;
  logic              misaligned;
  logic [XLEN/8-1:0] be_next;
  logic [XLEN-1:0]   wdata_next;

  assign dmem_page_fault_o = 1'b0;

  assign misaligned = ((dmem_size_i == 2'd1) && dmem_adr_i[0]) ||
                      ((dmem_size_i == 2'd2) && (dmem_adr_i[1:0] != 2'b00));

  // Byte enables and lane-replicated write data for the request on the inputs.
  // Loads get the same byte enables as stores of the same size.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    be_next    = 4'b1111;
    wdata_next = dmem_d_i;
    case (dmem_size_i)
      2'd0: begin
        be_next    = 4'b0001 << dmem_adr_i[1:0];
        wdata_next = {4{dmem_d_i[7:0]}};
      end
      2'd1: begin
        be_next    = 4'b0011 << dmem_adr_i[1:0];
        wdata_next = {2{dmem_d_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Single FSM process; all outputs are registered so they are glitch-free and
  // the bus fields stay constant for the whole BUSY phase.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= IDLE;
      cnt               <= 8'd0;
      bus_req_o         <= 1'b0;
      bus_adr_o         <= '0;
      bus_we_o          <= 1'b0;
      bus_be_o          <= '0;
      bus_d_o           <= '0;
      dmem_ack_o        <= 1'b0;
      dmem_err_o        <= 1'b0;
      dmem_misaligned_o <= 1'b0;
      dmem_q_o          <= '0;
    end else begin
      // Response flags are single-cycle pulses; only the transition into RESP
      // raises one of them.
      dmem_ack_o        <= 1'b0;
      dmem_err_o        <= 1'b0;
      dmem_misaligned_o <= 1'b0;

      case (state)
        IDLE: begin
          if (dmem_req_i) begin
            if (dmem_size_i == 2'd3) begin
              dmem_err_o <= 1'b1;
              state      <= RESP;
            end else if (misaligned) begin
              dmem_misaligned_o <= 1'b1;
              state             <= RESP;
            end else begin
              bus_req_o <= 1'b1;
              bus_adr_o <= {dmem_adr_i[XLEN-1:2], 2'b00};
              bus_we_o  <= dmem_we_i;
              bus_be_o  <= be_next;
              bus_d_o   <= wdata_next;
              cnt       <= 8'd0;
              state     <= BUSY;
            end
          end
        end

        BUSY: begin
          // Error has priority over acknowledge when both arrive together.
          if (bus_err_i) begin
            bus_req_o  <= 1'b0;
            dmem_err_o <= 1'b1;
            state      <= RESP;
          end else if (bus_ack_i) begin
            bus_req_o  <= 1'b0;
            dmem_ack_o <= 1'b1;
            if (!bus_we_o) begin
              dmem_q_o <= bus_q_i;
            end
            state <= RESP;
          end else if (cnt == LAST_CNT) begin
            bus_req_o  <= 1'b0;
            dmem_err_o <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        // One response cycle; a request still held high here is the one just
        // answered, so it is deliberately not looked at.
        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_dmem_ctrl
//
// Self-checking bench for riscv_dmem_ctrl (TIMEOUT=4 so the abandon path is
// reachable in a few cycles). A table of hand-computed vectors covers the
// named scenarios, a randomized phase compares against a transaction-level
// reference model, and a hand-written sequence covers reset during BUSY.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_ctrl;

  localparam int TB_TIMEOUT = 4;

  // Response kinds returned by the bench's bus responder.
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  // Expected core-side response.
  localparam int R_ACK = 0;
  localparam int R_ERR = 1;
  localparam int R_MIS = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dmem_req_i;
  logic [31:0] dmem_adr_i;
  logic [1:0]  dmem_size_i;
  logic        dmem_we_i;
  logic [31:0] dmem_d_i;
  logic        dmem_ack_o;
  logic        dmem_err_o;
  logic        dmem_misaligned_o;
  logic        dmem_page_fault_o;
  logic [31:0] dmem_q_o;
  logic        bus_req_o;
  logic [31:0] bus_adr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_d_o;
  logic        bus_ack_i;
  logic        bus_err_i;
  logic [31:0] bus_q_i;

  riscv_dmem_ctrl #(.XLEN(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .dmem_req_i        (dmem_req_i),
    .dmem_adr_i        (dmem_adr_i),
    .dmem_size_i       (dmem_size_i),
    .dmem_we_i         (dmem_we_i),
    .dmem_d_i          (dmem_d_i),
    .dmem_ack_o        (dmem_ack_o),
    .dmem_err_o        (dmem_err_o),
    .dmem_misaligned_o (dmem_misaligned_o),
    .dmem_page_fault_o (dmem_page_fault_o),
    .dmem_q_o          (dmem_q_o),
    .bus_req_o         (bus_req_o),
    .bus_adr_o         (bus_adr_o),
    .bus_we_o          (bus_we_o),
    .bus_be_o          (bus_be_o),
    .bus_d_o           (bus_d_o),
    .bus_ack_i         (bus_ack_i),
    .bus_err_i         (bus_err_i),
    .bus_q_i           (bus_q_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] adr;
    logic        we;
    logic [31:0] d;
    int          kind;      // bus response kind
    int          delay;     // 0-based BUSY cycle in which the bus responds
    logic [31:0] q_bus;     // read data supplied with the response
    int          exp_resp;
    logic [3:0]  exp_be;
    logic [31:0] exp_d;
    int          exp_busy;  // number of cycles bus_req_o is high
    logic [31:0] exp_q;     // dmem_q_o after the access
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_q  = 32'h0;
  vec_t        vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] resp_bits(input int r);
    case (r)
      R_ACK:   return 3'b100;
      R_ERR:   return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Transaction-level reference: outcome derived from the access rules using
  // plain arithmetic on sizes, offsets and the bus response timing.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_q);
    vec_t r = v;
    int bytes = 1 << v.size;
    int off   = int'(v.adr % 4);
    r.exp_be  = 4'(((1 << bytes) - 1) << off);
    for (int i = 0; i < 4; i++) r.exp_d[8*i +: 8] = v.d[8*(i % bytes) +: 8];
    if (v.size == 2'd3) begin
      r.exp_resp = R_ERR; r.exp_busy = 0;
    end else if ((v.adr % bytes) != 0) begin
      r.exp_resp = R_MIS; r.exp_busy = 0;
    end else if (v.kind == K_NONE || v.delay >= TB_TIMEOUT) begin
      r.exp_resp = R_ERR; r.exp_busy = TB_TIMEOUT;
    end else begin
      r.exp_resp = (v.kind == K_ACK) ? R_ACK : R_ERR;
      r.exp_busy = v.delay + 1;
    end
    r.exp_q = (r.exp_resp == R_ACK && !v.we) ? v.q_bus : prev_q;
    return r;
  endfunction

  // Runs one access starting at posedge+1 with the controller idle, acting as
  // the bus slave; returns at posedge+1 with the controller idle again.
  task automatic run_txn(input vec_t v, input string tag);
    int  cyc  = 0;
    int  busy = 0;
    bit  done = 0;
    dmem_req_i  = 1'b1;
    dmem_adr_i  = v.adr;
    dmem_size_i = v.size;
    dmem_we_i   = v.we;
    dmem_d_i    = v.d;
    // Stray bus responses outside BUSY must be ignored.
    bus_ack_i   = 1'($urandom);
    bus_err_i   = 1'($urandom);
    bus_q_i     = $urandom;
    check({tag, " idle_bus_req"}, 32'(bus_req_o), 32'h0);
    while (!done && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      bus_q_i   = $urandom;
      if (dmem_ack_o || dmem_err_o || dmem_misaligned_o) begin
        done = 1;
        check({tag, " resp_flags"}, 32'({dmem_ack_o, dmem_err_o, dmem_misaligned_o}),
              32'(resp_bits(v.exp_resp)));
        check({tag, " resp_cycle"}, 32'(cyc), 32'(v.exp_busy + 1));
        check({tag, " resp_bus_req"}, 32'(bus_req_o), 32'h0);
        check({tag, " dmem_q"}, dmem_q_o, v.exp_q);
      end else if (bus_req_o) begin
        check({tag, " bus_adr"}, bus_adr_o, v.adr & 32'hFFFF_FFFC);
        check({tag, " bus_be"},  32'(bus_be_o), 32'(v.exp_be));
        check({tag, " bus_d"},   bus_d_o, v.exp_d);
        check({tag, " bus_we"},  32'(bus_we_o), 32'(v.we));
        if (busy == v.delay && v.kind != K_NONE) begin
          bus_ack_i = (v.kind != K_ERR);
          bus_err_i = (v.kind != K_ACK);
          bus_q_i   = v.q_bus;
        end
        busy++;
      end
    end
    if (!done) check({tag, " resp_missing"}, 32'h0, 32'h1);
    check({tag, " busy_cycles"}, 32'(busy), 32'(v.exp_busy));
    // Request stays high through the RESP cycle; stray bus strobes again.
    bus_ack_i = 1'($urandom);
    bus_err_i = 1'($urandom);
    @(posedge clk_i); #1;
    check({tag, " no_reissue"}, 32'({bus_req_o, dmem_ack_o, dmem_err_o, dmem_misaligned_o}), 32'h0);
    dmem_req_i = 1'b0;
    bus_ack_i  = 1'b0;
    bus_err_i  = 1'b0;
    @(posedge clk_i); #1;
    check({tag, " idle_after"}, 32'({bus_req_o, dmem_ack_o, dmem_err_o, dmem_misaligned_o}), 32'h0);
    model_q = v.exp_q;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // size adr we d kind delay q_bus | resp be d busy q
    vecs[0]  = '{2'd2, 32'h104, 1'b0, 32'h0, K_ACK, 2, 32'hDEADBEEF,
                 R_ACK, 4'b1111, 32'h0, 3, 32'hDEADBEEF};
    vecs[1]  = '{2'd0, 32'h203, 1'b1, 32'h123456A5, K_ACK, 0, 32'h0,
                 R_ACK, 4'b1000, 32'hA5A5A5A5, 1, 32'hDEADBEEF};
    vecs[2]  = '{2'd1, 32'h101, 1'b0, 32'h0, K_ACK, 0, 32'h0,
                 R_MIS, 4'b0000, 32'h0, 0, 32'hDEADBEEF};
    vecs[3]  = '{2'd2, 32'h200, 1'b0, 32'h0, K_BOTH, 1, 32'h01020304,
                 R_ERR, 4'b1111, 32'h0, 2, 32'hDEADBEEF};
    vecs[4]  = '{2'd2, 32'h300, 1'b0, 32'h0, K_NONE, 255, 32'h0,
                 R_ERR, 4'b1111, 32'h0, 4, 32'hDEADBEEF};
    vecs[5]  = '{2'd3, 32'h0, 1'b0, 32'h0, K_ACK, 0, 32'h0,
                 R_ERR, 4'b0000, 32'h0, 0, 32'hDEADBEEF};
    vecs[6]  = '{2'd1, 32'h102, 1'b1, 32'hFFFF1234, K_ACK, 0, 32'h0,
                 R_ACK, 4'b1100, 32'h12341234, 1, 32'hDEADBEEF};
    vecs[7]  = '{2'd2, 32'h106, 1'b0, 32'h0, K_ACK, 0, 32'h0,
                 R_MIS, 4'b0000, 32'h0, 0, 32'hDEADBEEF};
    vecs[8]  = '{2'd0, 32'h101, 1'b0, 32'h0, K_ACK, 3, 32'h11223344,
                 R_ACK, 4'b0010, 32'h0, 4, 32'h11223344};
    vecs[9]  = '{2'd2, 32'h10, 1'b1, 32'hCAFEF00D, K_ERR, 0, 32'h0,
                 R_ERR, 4'b1111, 32'hCAFEF00D, 1, 32'h11223344};
    vecs[10] = '{2'd1, 32'h42, 1'b0, 32'h0, K_ACK, 1, 32'h55AA55AA,
                 R_ACK, 4'b1100, 32'h0, 2, 32'h55AA55AA};

    rst_ni      = 1'b0;
    dmem_req_i  = 1'b0;
    dmem_adr_i  = '0;
    dmem_size_i = '0;
    dmem_we_i   = 1'b0;
    dmem_d_i    = '0;
    bus_ack_i   = 1'b0;
    bus_err_i   = 1'b0;
    bus_q_i     = '0;
    #12;
    check("reset_ctrl_outputs", 32'({dmem_ack_o, dmem_err_o, dmem_misaligned_o,
          dmem_page_fault_o, bus_req_o, bus_we_o, bus_be_o}), 32'h0);
    check("reset_bus_adr", bus_adr_o, 32'h0);
    check("reset_bus_d", bus_d_o, 32'h0);
    check("reset_dmem_q", dmem_q_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted in the middle of BUSY.
    dmem_req_i  = 1'b1;
    dmem_adr_i  = 32'h80;
    dmem_size_i = 2'd2;
    dmem_we_i   = 1'b0;
    @(posedge clk_i); #1;
    check("rstbusy bus_req_before", 32'(bus_req_o), 32'h1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("rstbusy bus_req_async", 32'(bus_req_o), 32'h0);
    dmem_req_i = 1'b0;
    bus_ack_i  = 1'b1;
    bus_q_i    = 32'hBAD0BAD0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("rstbusy no_response", 32'({bus_req_o, dmem_ack_o, dmem_err_o, dmem_misaligned_o}), 32'h0);
      bus_ack_i = 1'b0;
    end
    check("rstbusy dmem_q_cleared", dmem_q_o, 32'h0);
    model_q = 32'h0;
    v = '{2'd2, 32'h84, 1'b0, 32'h0, K_ACK, 0, 32'h600DF00D, 0, 4'h0, 32'h0, 0, 32'h0};
    run_txn(model(v, model_q), "after_reset");

    // Randomized accesses against the reference model.
    for (int n = 0; n < 200; n++) begin
      int r = $urandom_range(0, 7);
      v.size  = (r == 7) ? 2'd3 : 2'(r % 3);
      v.adr   = $urandom;
      v.we    = 1'($urandom);
      v.d     = $urandom;
      v.kind  = $urandom_range(0, 2);
      v.delay = $urandom_range(0, 5);
      v.q_bus = $urandom;
      run_txn(model(v, model_q), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
